// File: rtl/shift_arbiter.sv
// shift_arbiter: one registered 16-bit shifter (left, logical right,
// arithmetic right) shared round-robin between two requesters. Each
// requester has a valid/ready request channel and a valid/ready response
// channel. Only one operation is in flight at a time.
module shift_arbiter #(
    parameter int W  = 16,
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*W-1:0]    req_in,
    input  logic [2*AW-1:0]   req_amt,
    input  logic [1:0]        req_mode,
    input  logic [1:0]        req_dir,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    in_q, in_d;
    logic [AW-1:0]   amt_q, amt_d;
    logic            mode_q, mode_d;
    logic            dir_q, dir_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;

    logic            win_s;
    logic            any_s;

    // Shift amounts of W or more saturate to all-fill; the fill bit is the
    // sign only for arithmetic right shifts, zero otherwise.
    function automatic logic [W-1:0] shift_op(
        input logic [W-1:0]  d,
        input logic [AW-1:0] amt,
        input logic          mode,
        input logic          dir
    );
        logic [W-1:0] r;
        logic         fill;
        fill = dir & mode & d[W-1];
        if (amt >= AW'(W)) begin
            r = {W{fill}};
        end else if (!dir) begin
            r = d << amt;
        end else if (mode) begin
            r = $unsigned($signed(d) >>> amt);
        end else begin
            r = d >> amt;
        end
        return r;
    endfunction

    // Round-robin winner: a lone requester wins, on contention the one
    // that did not win last time.
    always_comb begin
        win_s = 1'b0;
        any_s = 1'b0;
        case (req_valid)
            2'b01: begin
                win_s = 1'b0;
                any_s = 1'b1;
            end
            2'b10: begin
                win_s = 1'b1;
                any_s = 1'b1;
            end
            2'b11: begin
                win_s = ~last_grant_q;
                any_s = 1'b1;
            end
            default: begin
                win_s = 1'b0;
                any_s = 1'b0;
            end
        endcase
    end

    // Next-state, operand capture and result computation.
    always_comb begin
        state_d      = state_q;
        in_d         = in_q;
        amt_d        = amt_q;
        mode_d       = mode_q;
        dir_d        = dir_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    state_d      = EXEC;
                    in_d         = win_s ? req_in[2*W-1:W] : req_in[W-1:0];
                    amt_d        = win_s ? req_amt[2*AW-1:AW] : req_amt[AW-1:0];
                    mode_d       = win_s ? req_mode[1] : req_mode[0];
                    dir_d        = win_s ? req_dir[1] : req_dir[0];
                    owner_d      = win_s;
                    last_grant_d = win_s;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rsp_data_d = shift_op(in_q, amt_q, mode_q, dir_q);
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_q         <= {W{1'b0}};
            amt_q        <= {AW{1'b0}};
            mode_q       <= 1'b0;
            dir_q        <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= {W{1'b0}};
        end else begin
            state_q      <= state_d;
            in_q         <= in_d;
            amt_q        <= amt_d;
            mode_q       <= mode_d;
            dir_q        <= dir_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // Output decode; req_ready is held low while reset is asserted so no
    // handshake can appear to complete during reset.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (state_q == IDLE) && any_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = 2'b00;
        end
        if (state_q == RESP) begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
        end else begin
            rsp_valid = 2'b00;
        end
        rsp_data = rsp_data_q;
        busy     = (state_q != IDLE);
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: the driver pushes the expected
// response at each accepted request, a negedge monitor pops and compares
// whenever a response handshake is presented.
module tb_shift_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_in;
    logic [9:0]  req_amt;
    logic [1:0]  req_mode;
    logic [1:0]  req_dir;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_data;
    logic        busy;

    typedef struct packed {
        logic [1:0]  vld;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    shift_arbiter #(.W(16), .AW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in    (req_in),
        .req_amt   (req_amt),
        .req_mode  (req_mode),
        .req_dir   (req_dir),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: pop one expectation per response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ((rsp_valid & rsp_ready) != 2'b00)) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b data=0x%0h, expected none", rsp_valid, rsp_data);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.vld});
                chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
            end
        end
    end

    // Present one request, wait (bounded) for its grant, push the expectation.
    task automatic issue(input int idx, input logic [15:0] din, input logic [4:0] amt,
                         input logic mode, input logic dir, input logic [15:0] expd,
                         input bit push);
        bit   got;
        exp_t e;
        got = 1'b0;
        @(posedge clk); #1;
        if (idx == 0) begin
            req_in[15:0] = din;
            req_amt[4:0] = amt;
        end else begin
            req_in[31:16] = din;
            req_amt[9:5]  = amt;
        end
        req_mode[idx]  = mode;
        req_dir[idx]   = dir;
        req_valid[idx] = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (req_ready[idx]) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        chk("grant_seen", {31'd0, got}, 32'd1);
        if (got) begin
            chk("req_ready_onehot", {30'd0, req_ready}, (idx == 0) ? 32'd1 : 32'd2);
            if (push) begin
                e.vld  = (idx == 0) ? 2'b01 : 2'b10;
                e.data = expd;
                sb_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        // Scramble the operands after acceptance; the latched copy must be used.
        if (idx == 0) begin
            req_in[15:0] = ~din;
            req_amt[4:0] = ~amt;
        end else begin
            req_in[31:16] = ~din;
            req_amt[9:5]  = ~amt;
        end
        req_mode[idx] = ~mode;
        req_dir[idx]  = ~dir;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!busy) begin
                idle = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("idle_timeout", {31'd0, idle}, 32'd1);
    endtask

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_in    = 32'd0;
        req_amt   = 10'd0;
        req_mode  = 2'b00;
        req_dir   = 2'b00;
        rsp_ready = 2'b11;

        // Reset state, including no grant while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        req_valid = 2'b11;
        #1;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;

        // Single request with latency check.
        issue(0, 16'h0001, 5'd4, 1'b0, 1'b0, 16'h0010, 1'b1);
        chk("lat_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("lat_exec_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("lat_resp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("lat_resp_data", {16'd0, rsp_data}, 32'h0010);
        wait_idle();

        // Right shifts, saturating amounts and amt=0.
        issue(1, 16'h8000, 5'd3,  1'b1, 1'b1, 16'hF000, 1'b1); wait_idle();
        issue(1, 16'h8000, 5'd3,  1'b0, 1'b1, 16'h1000, 1'b1); wait_idle();
        issue(1, 16'h8000, 5'd20, 1'b1, 1'b1, 16'hFFFF, 1'b1); wait_idle();
        issue(1, 16'h1234, 5'd16, 1'b0, 1'b1, 16'h0000, 1'b1); wait_idle();
        issue(0, 16'h7FFF, 5'd31, 1'b1, 1'b1, 16'h0000, 1'b1); wait_idle();
        issue(0, 16'hFFFF, 5'd16, 1'b1, 1'b0, 16'h0000, 1'b1); wait_idle();
        issue(0, 16'hB00F, 5'd15, 1'b1, 1'b0, 16'h8000, 1'b1); wait_idle();
        issue(0, 16'hA5A5, 5'd0,  1'b0, 1'b0, 16'hA5A5, 1'b1); wait_idle();
        issue(0, 16'hA5A5, 5'd0,  1'b0, 1'b1, 16'hA5A5, 1'b1); wait_idle();
        issue(0, 16'hA5A5, 5'd0,  1'b1, 1'b1, 16'hA5A5, 1'b1); wait_idle();

        // Contention from reset: alternating grants, one idle cycle between ops.
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_in    = {16'h0300, 16'h0003};
        req_amt   = {5'd4, 5'd1};
        req_mode  = 2'b00;
        req_dir   = 2'b10;
        req_valid = 2'b11;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        for (int n = 0; n < 4; n++) begin
            chk("cont_idle_busy", {31'd0, busy}, 32'd0);
            chk("cont_grant", {30'd0, req_ready}, (n % 2 == 0) ? 32'd1 : 32'd2);
            e.vld  = (n % 2 == 0) ? 2'b01 : 2'b10;
            e.data = (n % 2 == 0) ? 16'h0006 : 16'h0030;
            sb_q.push_back(e);
            @(posedge clk); #1;
            chk("cont_exec_busy", {31'd0, busy}, 32'd1);
            chk("cont_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
            chk("cont_resp_busy", {31'd0, busy}, 32'd1);
            chk("cont_resp_owner", {30'd0, rsp_valid}, (n % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        wait_idle();

        // Backpressure on requester 0 while requester 1 waits.
        rsp_ready = 2'b10;
        issue(0, 16'h00F0, 5'd2, 1'b0, 1'b1, 16'h003C, 1'b1);
        req_in[31:16] = 16'h0001;
        req_amt[9:5]  = 5'd15;
        req_mode[1]   = 1'b0;
        req_dir[1]    = 1'b0;
        req_valid[1]  = 1'b1;
        #1;
        chk("bp_exec_req_ready", {30'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", {16'd0, rsp_data}, 32'h003C);
            chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        chk("bp_req1_grant", {30'd0, req_ready}, 32'd2);
        e.vld  = 2'b10;
        e.data = 16'h8000;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_idle();

        // Reset during EXEC: op discarded, priority returns to requester 0.
        issue(0, 16'h1111, 5'd1, 1'b0, 1'b0, 16'h2222, 1'b0);
        rst_n     = 1'b0;
        req_in    = {16'h0040, 16'h0005};
        req_amt   = {5'd3, 5'd2};
        req_mode  = 2'b00;
        req_dir   = 2'b10;
        req_valid = 2'b11;
        @(posedge clk); #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("mid_rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("mid_rst_req_ready", {30'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", {30'd0, req_ready}, 32'd1);
        e.vld  = 2'b01;
        e.data = 16'h0014;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle();

        // Drain the scoreboard.
        for (int c = 0; c < 20; c++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
